// File: rtl/serial_add_ctrl.sv
// Control wrapper around a bit-serial full adder: latches operands on start,
// shifts them LSB-first one bit per clock, and rebuilds the parallel result.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic last;
  logic bit_s;
  logic carry_n;
  logic busy_nxt;
  logic done_nxt;

  assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign bit_s   = ra[0] ^ rb[0] ^ carry;
  assign carry_n = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE or DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below so busy/done come from flops
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_SHIFT: busy_nxt = 1'b1;
      ST_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, registered carry, counter, result and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept) begin
        ra    <= a;
        rb    <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
        ovf   <= 1'b0;
      end else if (state == ST_SHIFT) begin
        ra    <= {1'b0, ra[WIDTH-1:1]};
        rb    <= {1'b0, rb[WIDTH-1:1]};
        carry <= carry_n;
        sum   <= {bit_s, sum[WIDTH-1:1]};
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          cout <= carry_n;
          ovf  <= carry ^ carry_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases with literal results,
// then randomized traffic against a cycle-level arithmetic model.
module tb_serial_add_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: A + (B or ~B) + sub, overflow from MSB carries
  task automatic calc(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                      output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb   = xs ? ~xb : xb;
    full = {1'b0, xa} + {1'b0, bb} + (W+1)'(xs);
    low  = W'(xa[W-2:0]) + W'(bb[W-2:0]) + W'(xs);
    s    = full[W-1:0];
    co   = full[W];
    ov   = low[W-1] ^ full[W];
  endtask

  // Model: phase 0 idle, 1 busy (left cycles to go), 2 done
  int           ph = 0;
  int           left = 0;
  logic [W-1:0] m_sum = '0, p_sum;
  logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout, p_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (ph != 1 && start) begin
      calc(a, b, sub, p_sum, p_cout, p_ovf);
      ph = 1; left = W; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (ph == 1) begin
      left--;
      if (left == 0) begin
        ph = 2; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (ph == 2) begin
      ph = 0;
    end
    #1;
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(ph == 1));
      chk("done", 32'(done), 32'(ph == 2));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("ovf",  32'(ovf),  32'(m_ovf));
      if (ph != 1) chk("sum", 32'(sum), 32'(m_sum));
    end
  end

  // Run one op; inj>0 pulses a stray start (AA/55) at that busy cycle
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input int inj,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; sub = xs;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = (n == inj);
      if (n == inj) begin a = 8'hAA; b = 8'h55; end
    end while (!done && n < 40);
    start = 1'b0;
    chk({name, "_latency"}, 32'(n), 32'(W + 1));
    chk({name, "_sum"},  32'(sum),  32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  initial begin
    int n;
    int dones;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 0, 8'h7F, 1'b0, 1'b0);
    run_op("addff_01", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    run_op("add7f_01", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
    run_op("sub05_07", 8'h05, 8'h07, 1'b1, 0, 8'hFE, 1'b0, 1'b0);
    run_op("sub80_01", 8'h80, 8'h01, 1'b1, 0, 8'h7F, 1'b1, 1'b1);
    run_op("ignored",  8'h10, 8'h20, 1'b0, 3, 8'h30, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h30);

    // Back-to-back with start held high
    start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
    n = 0; dones = 0;
    while (dones < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin a = 8'h02; b = 8'h02; end
      if (done) begin
        dones++;
        chk("b2b_time", 32'(n), 32'(dones * (W + 1)));
        chk("b2b_sum", 32'(sum), (dones == 1) ? 32'h02 : 32'h04);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(dones), 32'd2);

    // Abort mid-operation, then confirm no residual carry
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    run_op("post_abort", 8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 1'b0);

    // Random traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 3) == 0);
      sub   = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
